// File: rtl/game_sequencer_if.sv
// Game sequencer bus: control inputs from the input/collision logic and
// the registered status outputs consumed by the display and motion logic.
interface game_sequencer_if;
  logic        start_btn;
  logic        pause_btn;
  logic        frame_tick;
  logic        score_in;
  logic        end_game_in;
  logic [1:0]  state;
  logic        run;
  logic        obj_respawn;
  logic [11:0] score_bcd;
  logic [11:0] hi_score_bcd;
  logic [2:0]  level;
  logic        crash_flash;

  // Stimulus side: drives buttons and collision flags, observes status.
  modport master (
    output start_btn, pause_btn, frame_tick, score_in, end_game_in,
    input  state, run, obj_respawn, score_bcd, hi_score_bcd, level, crash_flash
  );

  // Sequencer side.
  modport slave (
    input  start_btn, pause_btn, frame_tick, score_in, end_game_in,
    output state, run, obj_respawn, score_bcd, hi_score_bcd, level, crash_flash
  );
endinterface

// File: rtl/game_sequencer.sv
// Game sequencer: IDLE/PLAY/PAUSE/OVER control for a driving game, with a
// saturating three-digit BCD score, best-score tracking, speed levels and a
// game-over lockout timed in video frames. All outputs are registered.
module game_sequencer #(
  parameter int CRASH_FRAMES = 120,
  parameter int LEVEL_STEP   = 10,
  parameter int MAX_LEVEL    = 7
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // Frame counter must hold CRASH_FRAMES and always expose bit 3 for the blink.
  localparam int FC_BITS = $clog2(CRASH_FRAMES + 1);
  localparam int FW      = (FC_BITS < 4) ? 4 : FC_BITS;
  localparam int PW      = (LEVEL_STEP < 2) ? 1 : $clog2(LEVEL_STEP);

  localparam logic [FW-1:0] FRAME_LIMIT = FW'(CRASH_FRAMES);
  localparam logic [PW-1:0] PTS_LAST    = PW'(LEVEL_STEP - 1);
  localparam logic [2:0]    LEVEL_TOP   = 3'(MAX_LEVEL);

  // Increment a three-digit BCD value, holding at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (v != 12'h999) begin
      if (d0 != 4'd9) begin
        d0 = d0 + 4'd1;
      end else begin
        d0 = 4'd0;
        if (d1 != 4'd9) begin
          d1 = d1 + 4'd1;
        end else begin
          d1 = 4'd0;
          d2 = d2 + 4'd1;
        end
      end
    end
    return {d2, d1, d0};
  endfunction

  // Registered state
  logic [1:0]    state_q;
  logic [11:0]   score_q;
  logic [11:0]   hi_q;
  logic [2:0]    level_q;
  logic [PW-1:0] pts_q;
  logic [FW-1:0] frame_q;
  logic          start_prev, pause_prev, score_prev;
  logic          run_q, respawn_q, flash_q;

  // Next-state values
  logic [1:0]    state_n;
  logic [11:0]   score_n;
  logic [11:0]   hi_n;
  logic [2:0]    level_n;
  logic [PW-1:0] pts_n;
  logic [FW-1:0] frame_n;
  logic          respawn_n;

  logic start_edge, pause_edge, score_edge;

  assign start_edge = bus.start_btn & ~start_prev;
  assign pause_edge = bus.pause_btn & ~pause_prev;
  assign score_edge = bus.score_in  & ~score_prev;

  // Next-state and datapath decisions for every state.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned and infers a latch.
    state_n   = state_q;
    score_n   = score_q;
    hi_n      = hi_q;
    level_n   = level_q;
    pts_n     = pts_q;
    frame_n   = frame_q;
    respawn_n = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_n = ST_PLAY;
          score_n = 12'h000;
          level_n = 3'd0;
          pts_n   = '0;
        end
      end

      ST_PLAY: begin
        if (bus.end_game_in) begin
          // Crash wins: a same-cycle score edge is dropped entirely.
          state_n = ST_OVER;
          frame_n = '0;
          // Valid BCD orders the same as its numeric value, so a plain compare works.
          if (score_q > hi_q) hi_n = score_q;
        end else begin
          if (pause_edge) state_n = ST_PAUSE;
          // A score edge still counts alongside a pause edge.
          if (score_edge) begin
            respawn_n = 1'b1;
            score_n   = bcd_inc(score_q);
            if (pts_q == PTS_LAST) begin
              pts_n = '0;
              if (level_q < LEVEL_TOP) level_n = level_q + 3'd1;
            end else begin
              pts_n = pts_q + PW'(1);
            end
          end
        end
      end

      ST_PAUSE: begin
        if (pause_edge) state_n = ST_PLAY;
      end

      ST_OVER: begin
        if (bus.frame_tick && frame_q < FRAME_LIMIT) frame_n = frame_q + FW'(1);
        if (start_edge && frame_q == FRAME_LIMIT) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Edge-detect history registers sample every cycle regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Button history starts high so a button held through reset must be
      // released and pressed again before it registers.
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      score_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      start_prev <= bus.start_btn;
      pause_prev <= bus.pause_btn;
      score_prev <= bus.score_in;
    end
  end

  // Main state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      score_q   <= 12'h000;
      hi_q      <= 12'h000;
      level_q   <= 3'd0;
      pts_q     <= '0;
      frame_q   <= '0;
      run_q     <= 1'b0;
      respawn_q <= 1'b0;
      flash_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      score_q   <= score_n;
      hi_q      <= hi_n;
      level_q   <= level_n;
      pts_q     <= pts_n;
      frame_q   <= frame_n;
      run_q     <= (state_n == ST_PLAY);
      respawn_q <= respawn_n;
      flash_q   <= (state_n == ST_OVER) & frame_n[3];
    end
  end

  assign bus.state        = state_q;
  assign bus.run          = run_q;
  assign bus.obj_respawn  = respawn_q;
  assign bus.score_bcd    = score_q;
  assign bus.hi_score_bcd = hi_q;
  assign bus.level        = level_q;
  assign bus.crash_flash  = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a cycle-by-cycle vector table for the
// main flow, then hand-written sequences for hold, saturation, crash
// priority, best-score and mid-game reset behaviour.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   resp_cnt = 0;

  game_sequencer_if bus ();

  game_sequencer #(
    .CRASH_FRAMES(4),
    .LEVEL_STEP  (10),
    .MAX_LEVEL   (7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, pause, tick, score, endg;
    logic [1:0]  st;
    logic        rn, rsp;
    logic [11:0] sc, hi;
    logic [2:0]  lv;
    logic        fl;
  } vec_t;

  vec_t vec[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.obj_respawn) resp_cnt++;
  endtask

  task automatic set_in(input logic s, p, t, sc, e);
    bus.start_btn   = s;
    bus.pause_btn   = p;
    bus.frame_tick  = t;
    bus.score_in    = sc;
    bus.end_game_in = e;
  endtask

  task automatic pulse_score(input int n);
    for (int i = 0; i < n; i++) begin
      bus.score_in = 1'b1;
      step();
      bus.score_in = 1'b0;
      step();
    end
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic lockout_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
    end
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    //            st  pa tk sc eg  state rn rsp score    hi      lv fl
    vec[0]  = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 12'h000, 12'h000, 0, 0};
    vec[1]  = '{1, 0, 0, 0, 0, 2'd1, 1, 0, 12'h000, 12'h000, 0, 0};
    vec[2]  = '{1, 0, 0, 1, 0, 2'd1, 1, 1, 12'h001, 12'h000, 0, 0};
    vec[3]  = '{0, 0, 0, 1, 0, 2'd1, 1, 0, 12'h001, 12'h000, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 2'd1, 1, 0, 12'h001, 12'h000, 0, 0};
    vec[5]  = '{0, 0, 0, 1, 0, 2'd1, 1, 1, 12'h002, 12'h000, 0, 0};
    vec[6]  = '{0, 1, 0, 0, 0, 2'd2, 0, 0, 12'h002, 12'h000, 0, 0};
    vec[7]  = '{0, 0, 0, 1, 0, 2'd2, 0, 0, 12'h002, 12'h000, 0, 0};
    vec[8]  = '{0, 0, 0, 0, 1, 2'd2, 0, 0, 12'h002, 12'h000, 0, 0};
    vec[9]  = '{1, 1, 0, 0, 0, 2'd1, 1, 0, 12'h002, 12'h000, 0, 0};
    vec[10] = '{0, 0, 0, 1, 0, 2'd1, 1, 1, 12'h003, 12'h000, 0, 0};
    vec[11] = '{0, 0, 0, 0, 0, 2'd1, 1, 0, 12'h003, 12'h000, 0, 0};
    vec[12] = '{0, 1, 0, 1, 0, 2'd2, 0, 1, 12'h004, 12'h000, 0, 0};
    vec[13] = '{0, 0, 0, 0, 0, 2'd2, 0, 0, 12'h004, 12'h000, 0, 0};
    vec[14] = '{0, 1, 0, 0, 0, 2'd1, 1, 0, 12'h004, 12'h000, 0, 0};
    vec[15] = '{0, 0, 0, 0, 0, 2'd1, 1, 0, 12'h004, 12'h000, 0, 0};
    vec[16] = '{0, 0, 0, 1, 1, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[17] = '{0, 0, 0, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[18] = '{1, 0, 0, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[19] = '{0, 0, 1, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[20] = '{0, 0, 1, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[21] = '{0, 0, 1, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[22] = '{1, 0, 0, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[23] = '{0, 0, 1, 0, 0, 2'd3, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[24] = '{1, 0, 0, 0, 0, 2'd0, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[25] = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 12'h004, 12'h004, 0, 0};
    vec[26] = '{1, 0, 0, 0, 0, 2'd1, 1, 0, 12'h000, 12'h004, 0, 0};

    set_in(0, 0, 0, 0, 0);
    #3;
    // Async reset takes effect before any clock edge.
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_run", 32'(bus.run), 32'd0);
    check("reset_score", 32'(bus.score_bcd), 32'h000);
    check("reset_hi", 32'(bus.hi_score_bcd), 32'h000);
    check("reset_level", 32'(bus.level), 32'd0);
    check("reset_respawn", 32'(bus.obj_respawn), 32'd0);
    check("reset_flash", 32'(bus.crash_flash), 32'd0);
    step();
    rst = 1'b0;

    // Main flow table
    for (int i = 0; i < 27; i++) begin
      set_in(vec[i].start, vec[i].pause, vec[i].tick, vec[i].score, vec[i].endg);
      step();
      check($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vec[i].st));
      check($sformatf("vec%0d_run", i), 32'(bus.run), 32'(vec[i].rn));
      check($sformatf("vec%0d_respawn", i), 32'(bus.obj_respawn), 32'(vec[i].rsp));
      check($sformatf("vec%0d_score", i), 32'(bus.score_bcd), 32'(vec[i].sc));
      check($sformatf("vec%0d_hi", i), 32'(bus.hi_score_bcd), 32'(vec[i].hi));
      check($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vec[i].lv));
      check($sformatf("vec%0d_flash", i), 32'(bus.crash_flash), 32'(vec[i].fl));
    end

    // Held score_in counts once
    set_in(0, 0, 0, 1, 0);
    resp_cnt = 0;
    for (int i = 0; i < 40; i++) step();
    bus.score_in = 1'b0;
    step();
    check("hold_score", 32'(bus.score_bcd), 32'h001);
    check("hold_respawns", 32'(resp_cnt), 32'd1);

    // 23 points -> level 2, then saturation at 999
    pulse_score(22);
    check("p23_score", 32'(bus.score_bcd), 32'h023);
    check("p23_level", 32'(bus.level), 32'd2);
    pulse_score(975);
    check("p998_score", 32'(bus.score_bcd), 32'h998);
    check("p998_level_sat", 32'(bus.level), 32'd7);
    resp_cnt = 0;
    pulse_score(3);
    check("sat_score", 32'(bus.score_bcd), 32'h999);
    check("sat_respawns", 32'(resp_cnt), 32'd3);
    check("sat_state", 32'(bus.state), 32'd1);

    // Crash and score edge in the same cycle at 005
    do_reset();
    check("rst2_hi", 32'(bus.hi_score_bcd), 32'h000);
    press_start();
    pulse_score(5);
    check("pre_crash_score", 32'(bus.score_bcd), 32'h005);
    bus.score_in = 1'b1;
    bus.end_game_in = 1'b1;
    step();
    check("crash_state", 32'(bus.state), 32'd3);
    check("crash_score", 32'(bus.score_bcd), 32'h005);
    check("crash_respawn", 32'(bus.obj_respawn), 32'd0);
    check("crash_hi", 32'(bus.hi_score_bcd), 32'h005);
    set_in(0, 0, 0, 0, 0);
    step();
    check("crash_no_late_respawn", 32'(bus.obj_respawn), 32'd0);

    // Lower score does not replace the best score
    lockout_ticks(4);
    press_start();
    check("back_idle", 32'(bus.state), 32'd0);
    press_start();
    pulse_score(3);
    bus.end_game_in = 1'b1;
    step();
    bus.end_game_in = 1'b0;
    check("low_over_state", 32'(bus.state), 32'd3);
    check("low_hi_kept", 32'(bus.hi_score_bcd), 32'h005);

    // Mid-game reset with best score 030 and score 012
    do_reset();
    press_start();
    pulse_score(30);
    bus.end_game_in = 1'b1;
    step();
    bus.end_game_in = 1'b0;
    check("hi30", 32'(bus.hi_score_bcd), 32'h030);
    lockout_ticks(4);
    press_start();
    press_start();
    pulse_score(12);
    check("mid_score", 32'(bus.score_bcd), 32'h012);
    check("mid_level", 32'(bus.level), 32'd1);
    bus.start_btn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_run", 32'(bus.run), 32'd0);
    check("midrst_score", 32'(bus.score_bcd), 32'h000);
    check("midrst_hi", 32'(bus.hi_score_bcd), 32'h000);
    check("midrst_level", 32'(bus.level), 32'd0);
    step();
    rst = 1'b0;

    // Start held through reset must not start a game
    for (int i = 0; i < 3; i++) step();
    check("held_start_ignored", 32'(bus.state), 32'd0);
    bus.start_btn = 1'b0;
    step();
    bus.start_btn = 1'b1;
    step();
    check("repress_start", 32'(bus.state), 32'd1);
    check("repress_run", 32'(bus.run), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
